// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and sequencer state encoding,
// used by the sequential ROL and reused by ROR/ADD.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ROT  = ST_ROT,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generator for rotate-style ops. C keeps the incoming
// value when nothing was shifted out; V always passes through.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    input  logic             has_carry,
    input  logic [3:0]       flag,
    input  logic             s,
    output logic [3:0]       new_flag
);

    always_comb begin
        new_flag = flag;
        if (s) begin
            new_flag[FLAG_N] = result[WIDTH-1];
            new_flag[FLAG_Z] = (result == '0);
            new_flag[FLAG_C] = has_carry ? carry_out : flag[FLAG_C];
            new_flag[FLAG_V] = flag[FLAG_V];
        end
    end

endmodule

// File: rtl/rol_seq.sv
// Sequential rotate, one bit per clock. Positive In2 rotates left, negative
// rotates right; result and flags are delivered under a start/busy/done handshake.
module rol_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [AMT_W-1:0] In2,
    input  logic [3:0]       Flag,
    input  logic             S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       New_Flag
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [3:0]       flag_in_q, flag_in_d;
    logic             s_q, s_d;
    logic             carry_q, carry_d;
    logic             rotated_q, rotated_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       new_flag_q, new_flag_d;
    logic [3:0]       flag_nxt;
    logic [AMT_W-1:0] neg_amt;

    // |-2^(AMT_W-1)| wraps to the same bit pattern, which is the correct unsigned magnitude.
    assign neg_amt = ~In2 + AMT_W'(1);

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result    (work_q),
        .carry_out (carry_q),
        .has_carry (rotated_q),
        .flag      (flag_in_q),
        .s         (s_q),
        .new_flag  (flag_nxt)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        dir_d      = dir_q;
        flag_in_d  = flag_in_q;
        s_d        = s_q;
        carry_d    = carry_q;
        rotated_d  = rotated_q;
        result_d   = result_q;
        new_flag_d = new_flag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d    = In1;
                    dir_d     = In2[AMT_W-1];
                    count_d   = In2[AMT_W-1] ? neg_amt : In2;
                    flag_in_d = Flag;
                    s_d       = S;
                    carry_d   = 1'b0;
                    rotated_d = 1'b0;
                    state_d   = ROT;
                end
            end
            ROT: begin
                if (count_q != '0) begin
                    if (dir_q) begin
                        work_d  = {work_q[0], work_q[WIDTH-1:1]};
                        carry_d = work_q[0];
                    end else begin
                        work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                        carry_d = work_q[WIDTH-1];
                    end
                    count_d   = count_q - AMT_W'(1);
                    rotated_d = 1'b1;
                end else begin
                    result_d   = work_q;
                    new_flag_d = flag_nxt;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
            flag_in_q  <= '0;
            s_q        <= 1'b0;
            carry_q    <= 1'b0;
            rotated_q  <= 1'b0;
            result_q   <= '0;
            new_flag_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            flag_in_q  <= flag_in_d;
            s_q        <= s_d;
            carry_q    <= carry_d;
            rotated_q  <= rotated_d;
            result_q   <= result_d;
            new_flag_q <= new_flag_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign Result   = result_q;
    assign New_Flag = new_flag_q;

endmodule

// File: tb/tb_rol_seq.sv
// Scoreboard bench for rol_seq: driver pushes model results, monitor pops on done.
module tb_rol_seq;

    localparam int WIDTH = 32;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] In1 = '0;
    logic [AMT_W-1:0] In2 = '0;
    logic [3:0]       Flag = '0;
    logic             S = 1'b0;
    logic             busy, done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       New_Flag;

    rol_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .In1(In1), .In2(In2),
        .Flag(Flag), .S(S), .busy(busy), .done(done),
        .Result(Result), .New_Flag(New_Flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: rotate by the signed amount using whole-word shifts.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] amt,
                                   input logic [3:0] f, input logic s);
        exp_t e;
        int   n;
        bit   right;
        logic [WIDTH-1:0] r;
        right = amt[AMT_W-1];
        n = right ? (1 << AMT_W) - int'(amt) : int'(amt);
        n = n % WIDTH;
        if (n == 0)     r = a;
        else if (right) r = (a >> n) | (a << (WIDTH - n));
        else            r = (a << n) | (a >> (WIDTH - n));
        e.res = r;
        e.flg = f;
        if (s) begin
            e.flg[3] = r[WIDTH-1];
            e.flg[2] = (r == 0);
            if (amt != 0) e.flg[1] = right ? r[WIDTH-1] : r[0];
        end
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(Result), 64'(e.res));
                chk("new_flag", 64'(New_Flag), 64'(e.flg));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Presents one request for a single accepting edge, then scrambles the inputs.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] amt,
                         input logic [3:0] f, input logic s, input bit expect_done);
        exp_t e;
        int   n;
        @(negedge clk);
        wait_idle();
        start = 1'b1; In1 = a; In2 = amt; Flag = f; S = s;
        n = amt[AMT_W-1] ? (1 << AMT_W) - int'(amt) : int'(amt);
        e = model(a, amt, f, s);
        e.cyc = cyc + n + 2;
        if (expect_done) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        In1 = $urandom; In2 = AMT_W'($urandom); Flag = 4'($urandom); S = 1'($urandom);
    endtask

    task automatic run(input logic [WIDTH-1:0] a, input logic [AMT_W-1:0] amt,
                       input logic [3:0] f, input logic s);
        issue(a, amt, f, s, 1'b1);
        wait_idle();
    endtask

    task automatic chk_const(input string name, input exp_t e, input logic [WIDTH-1:0] r,
                             input logic [3:0] fl);
        chk({name, "_model_res"}, 64'(e.res), 64'(r));
        chk({name, "_model_flg"}, 64'(e.flg), 64'(fl));
    endtask

    initial begin
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(Result), 64'd0);
        chk("reset_flag", 64'(New_Flag), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived expectations.
        chk_const("t1", model(32'd2, 4'd3, 4'b0000, 1'b1), 32'd16, 4'b0000);
        run(32'd2, 4'd3, 4'b0000, 1'b1);
        chk_const("t2", model(32'd4, 4'b1101, 4'b0000, 1'b1), 32'h80000000, 4'b1010);
        run(32'd4, 4'b1101, 4'b0000, 1'b1);
        chk_const("t3", model(32'hFFFFFFFF, 4'd7, 4'b0001, 1'b1), 32'hFFFFFFFF, 4'b1011);
        run(32'hFFFFFFFF, 4'd7, 4'b0001, 1'b1);
        chk_const("t4", model(32'd0, 4'd0, 4'b0010, 1'b1), 32'd0, 4'b0110);
        run(32'd0, 4'd0, 4'b0010, 1'b1);
        chk_const("t5", model(32'h80000001, 4'b1000, 4'b1100, 1'b0), 32'h01800000, 4'b1100);
        run(32'h80000001, 4'b1000, 4'b1100, 1'b0);
        chk("hold_result", 64'(Result), 64'h01800000);

        for (int i = 0; i < 40; i++)
            run($urandom, AMT_W'($urandom), 4'($urandom), 1'($urandom));

        // Start pulsed mid-rotation must be ignored.
        issue(32'h12345678, 4'd5, 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1; In1 = 32'hDEADBEEF; In2 = 4'd1; Flag = 4'b1111; S = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-rotation aborts without a done pulse.
        issue(32'hA5A5A5A5, 4'd6, 4'b0101, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(Result), 64'd0);
        chk("abort_flag", 64'(New_Flag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(32'd1, 4'd1, 4'b0000, 1'b1);
        chk("post_reset_result", 64'(Result), 64'd2);

        begin
            int t = 0;
            while (sb.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
